xr_port_ctrl: RTL

XR_PORT_CTRL -- requirements
Module: xr_port_ctrl

---
 rtl/xosera_pkg.sv | 9 +
 rtl/xr_port_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/xosera_pkg.sv
// Shared Xosera types: XR bus address/word types and port-controller constants.
package xosera_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] word_t;

  localparam addr_t INCR_RESET = 16'h0001;

endpackage

// File: rtl/xr_port_ctrl.sv
// Host-to-XR port controller: posts host writes and prefetches the word at the current address.
// Optional XR_PORT_AUTOINC_EN makes the post-access increment a host-loadable register.
module xr_port_ctrl
  import xosera_pkg::*;
(
  input  logic  clk,
  input  logic  reset_i,
  input  logic  wr_addr_stb_i,
  input  logic  wr_data_stb_i,
`ifdef XR_PORT_AUTOINC_EN
  input  logic  wr_incr_stb_i,
`endif
  input  logic  rd_data_stb_i,
  input  word_t host_data_i,
  output word_t rd_data_o,
  output logic  busy_o,
  output logic  overrun_o,
  output logic  xr_sel_o,
  output logic  xr_wr_o,
  output addr_t xr_addr_o,
  output word_t xr_data_o,
  input  logic  xr_ack_i,
  input  word_t xr_data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2
  } state_t;

  state_t state, state_n;
  addr_t  addr, addr_n;
  word_t  wdata, wdata_n;
  logic   wr_pend, wr_pend_n;
  logic   rd_pend, rd_pend_n;
  logic   overrun_n;
  logic   sel_n, wr_n;
  addr_t  xaddr_n;
  word_t  xdata_n;
  word_t  rd_data_n;
  addr_t  incr;
  logic   incr_stb;
  logic   stb_any;

`ifdef XR_PORT_AUTOINC_EN
  addr_t  incr_n;
  assign incr_stb = wr_incr_stb_i;
`else
  assign incr_stb = 1'b0;
  assign incr     = INCR_RESET;
`endif

  assign busy_o  = (state != IDLE) | wr_pend | rd_pend;
  assign stb_any = wr_addr_stb_i | wr_data_stb_i | rd_data_stb_i | incr_stb;

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    wdata_n   = wdata;
    wr_pend_n = wr_pend;
    rd_pend_n = rd_pend;
    overrun_n = overrun_o;
    sel_n     = xr_sel_o;
    wr_n      = xr_wr_o;
    xaddr_n   = xr_addr_o;
    xdata_n   = xr_data_o;
    rd_data_n = rd_data_o;
`ifdef XR_PORT_AUTOINC_EN
    incr_n    = incr;
`endif

    // Host strobes: only one is honoured per idle cycle; anything else is an overrun.
    if (busy_o) begin
      if (stb_any) overrun_n = 1'b1;
    end else if (wr_addr_stb_i) begin
      addr_n    = host_data_i;
      rd_pend_n = 1'b1;
      overrun_n = wr_data_stb_i | rd_data_stb_i | incr_stb;
    end else if (wr_data_stb_i) begin
      wdata_n   = host_data_i;
      wr_pend_n = 1'b1;
      if (rd_data_stb_i | incr_stb) overrun_n = 1'b1;
    end else if (rd_data_stb_i) begin
      addr_n    = addr + incr;
      rd_pend_n = 1'b1;
      if (incr_stb) overrun_n = 1'b1;
    end else if (incr_stb) begin
`ifdef XR_PORT_AUTOINC_EN
      incr_n    = host_data_i;
`endif
    end

    // XR request sequencing; the pending write always goes out before the prefetch.
    case (state)
      IDLE: begin
        if (wr_pend) begin
          state_n = WR_REQ;
          sel_n   = 1'b1;
          wr_n    = 1'b1;
          xaddr_n = addr;
          xdata_n = wdata;
        end else if (rd_pend) begin
          state_n = RD_REQ;
          sel_n   = 1'b1;
          wr_n    = 1'b0;
          xaddr_n = addr;
        end
      end
      WR_REQ: begin
        if (xr_ack_i) begin
          state_n   = IDLE;
          sel_n     = 1'b0;
          wr_n      = 1'b0;
          wr_pend_n = 1'b0;
          addr_n    = addr + incr;
          rd_pend_n = 1'b1;
        end
      end
      RD_REQ: begin
        if (xr_ack_i) begin
          state_n   = IDLE;
          sel_n     = 1'b0;
          rd_data_n = xr_data_i;
          rd_pend_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = 1'b0;
        wr_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      overrun_o <= 1'b0;
      xr_sel_o  <= 1'b0;
      xr_wr_o   <= 1'b0;
      xr_addr_o <= '0;
      xr_data_o <= '0;
      rd_data_o <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      wr_pend   <= wr_pend_n;
      rd_pend   <= rd_pend_n;
      overrun_o <= overrun_n;
      xr_sel_o  <= sel_n;
      xr_wr_o   <= wr_n;
      xr_addr_o <= xaddr_n;
      xr_data_o <= xdata_n;
      rd_data_o <= rd_data_n;
    end
  end

`ifdef XR_PORT_AUTOINC_EN
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) incr <= INCR_RESET;
    else         incr <= incr_n;
  end
`endif

endmodule
